// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher (straight form): one round per accepted round key.
// Round keys arrive last-round-first from the key expansion running in reverse.
module aes_inv_cipher #(
    parameter int K = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic         rk_valid,
    input  logic [127:0] rk,
    output logic         rk_ready,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);

    localparam int NR = (K == 256) ? 14 : (K == 192) ? 12 : 10;

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] plaintext_q, plaintext_d;
    logic [127:0] inv_core;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r of the output takes column (c - r) mod 4 of the input.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = INV_SBOX[s[127 - 8*i -: 8]];
        end
        return o;
    endfunction

    // Each output byte: {0e}a[r] ^ {0b}a[r+1] ^ {0d}a[r+2] ^ {09}a[r+3].
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a  [4];
        logic [7:0]   x2 [4];
        logic [7:0]   x4 [4];
        logic [7:0]   x8 [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127 - 8*(r + 4*c) -: 8];
                x2[r] = xtime(a[r]);
                x4[r] = xtime(x2[r]);
                x8[r] = xtime(x4[r]);
            end
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] =
                      (x8[r] ^ x4[r] ^ x2[r])
                    ^ (x8[(r + 1) % 4] ^ x2[(r + 1) % 4] ^ a[(r + 1) % 4])
                    ^ (x8[(r + 2) % 4] ^ x4[(r + 2) % 4] ^ a[(r + 2) % 4])
                    ^ (x8[(r + 3) % 4] ^ a[(r + 3) % 4]);
            end
        end
        return o;
    endfunction

    assign inv_core = inv_sub_bytes(inv_shift_rows(state_q));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        state_d     = state_q;
        plaintext_d = plaintext_q;
        rk_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d = ciphertext;
                    rnd_d   = 4'(NR - 1);
                    fsm_d   = INIT;
                end
            end
            INIT: begin
                rk_ready = 1'b1;
                busy     = 1'b1;
                if (rk_valid) begin
                    state_d = state_q ^ rk;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                rk_ready = 1'b1;
                busy     = 1'b1;
                if (rk_valid) begin
                    // Straight inverse cipher: key is added before InvMixColumns.
                    state_d = inv_mix_columns(inv_core ^ rk);
                    rnd_d   = rnd_q - 4'd1;
                    if (rnd_q == 4'd1) begin
                        fsm_d = FINAL;
                    end
                end
            end
            FINAL: begin
                rk_ready = 1'b1;
                busy     = 1'b1;
                if (rk_valid) begin
                    plaintext_d = inv_core ^ rk;
                    fsm_d       = DONE;
                end
            end
            DONE: begin
                done  = 1'b1;
                fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the datapath registers are reset as well, since plaintext is a visible
            // output that must read zero after reset and state must not leak an old block.
            fsm_q       <= IDLE;
            rnd_q       <= '0;
            state_q     <= '0;
            plaintext_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            state_q     <= state_d;
            plaintext_q <= plaintext_d;
        end
    end

    assign plaintext = plaintext_q;

endmodule

// File: doc/aes_inv_cipher.md
Name: aes_inv_cipher

Overview:
- Iterative AES inverse cipher: decrypts one 128-bit block per operation, one round per accepted round key.
- Consumes the round-key stream produced by the team's key-expansion block running in reverse mode, i.e. last round key first.
- Sits between the ciphertext source and the plaintext sink, next to the key-expansion block in the decrypt path.

Parameters:
- K, 128, key length in bits. Legal values 128, 192, 256. Sets Nr = 10 / 12 / 14 and number of round keys consumed = Nr+1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a decryption. Sampled only in IDLE.
- ciphertext  input  128  block to decrypt. Captured on an accepted start.
- rk_valid  input  1  round key on rk is valid
- rk  input  128  round key. Order: round Nr first, then Nr-1, ..., down to round 0.
- rk_ready  output  1  block will consume rk this cycle if rk_valid
- busy  output  1  operation in progress (start accepted, done not yet pulsed)
- done  output  1  one-cycle pulse: plaintext valid
- plaintext  output  128  decrypted block. Held until the next done.

Behaviour:
- Byte order follows FIPS-197 column-major: byte 0 = bits [127:120], column c = bits [127-32c -: 32].
- States: IDLE, INIT, ROUND, FINAL, DONE.
- A round-key transfer occurs on a rising edge where rk_valid & rk_ready.
- rk_ready = 1 in INIT, ROUND, FINAL; 0 in IDLE and DONE.
- busy = 1 in INIT, ROUND, FINAL.
- IDLE:
  - start=1 latches ciphertext into the state register, loads round counter rnd = Nr-1, moves to INIT.
  - rk_valid in IDLE is ignored.
- INIT:
  - On transfer: state <= state ^ rk (round Nr key).
  - Go to ROUND if Nr > 1 (always true for legal K).
- ROUND:
  - On transfer: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk), then rnd <= rnd-1.
  - If rnd == 1 at the transfer, go to FINAL.
  - This covers rounds Nr-1 down to 1, i.e. Nr-1 transfers.
- FINAL:
  - On transfer: plaintext <= InvSubBytes(InvShiftRows(state)) ^ rk (round 0 key).
  - Go to DONE.
- DONE:
  - done = 1 for exactly this one cycle, then IDLE.
  - A start during DONE is ignored; the next start is accepted in IDLE.
- Stall: with rk_valid low, state, counter and FSM hold; no partial update.
- Uses the straight inverse cipher, not the equivalent inverse cipher: the round key is added before InvMixColumns. The key stream therefore needs no InvMixColumns pre-processing.
- Latency with rk_valid held high: start accepted at edge 0; transfers at edges 1..Nr+1; done high in the cycle after edge Nr+1.
  - That is 12 cycles start-to-done for K=128, 14 for K=192, 16 for K=256.
  - Throughput is one block per Nr+3 cycles.
- start while busy is ignored. The ciphertext input is not re-sampled.
- Reset values: FSM=IDLE, rnd=0, state reg=0, plaintext=0, done=0, busy=0, rk_ready=0.
- Reset mid-operation: abandon the block immediately; all outputs take reset values on the next cycle.
  - The next start begins a fresh block.
  - Keys the source has already sent are not re-requested; the source is reset alongside.
- The block contains its own combinational inverse S-box (16 instances), InvShiftRows wiring and InvMixColumns GF(2^8) multiply-by-{09,0b,0d,0e}. No memories.

Test Plan:
- FIPS-197 C.1, K=128, rk_valid=1 always:
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; first rk 13111d7fe3944a17f307a78b4d2b30c5; last rk 000102030405060708090a0b0c0d0e0f.
  - Required: plaintext 00112233445566778899aabbccddeeff; done exactly 12 cycles after start; 11 transfers counted.
- FIPS-197 C.3, K=256:
  - Stimulus: ciphertext 8ea2b7ca516745bfeafc49904b496089; key 000102...1f expanded in reverse.
  - Required: plaintext 00112233445566778899aabbccddeeff; done 16 cycles after start; 15 transfers.
- Stall: same C.1 vector with rk_valid randomly deasserted ~50%.
  - Required: identical plaintext; done count = 1; no transfer while rk_valid=0.
  - State register is unchanged across stall cycles.
- Protocol:
  - rk_valid=1 in IDLE: rk_ready=0, no state change.
  - start pulsed in INIT and in DONE with a different ciphertext: ignored, C.1 result unaffected.
  - Back-to-back start in the IDLE cycle after done is accepted.
- Reset mid-op: assert reset after the 5th transfer.
  - Required next cycle: busy=0, done=0, rk_ready=0, plaintext=0.
  - A subsequent full C.1 run then yields the correct plaintext.
